vga_plot_arbiter: RTL and testbench

- Merges plot requests from up to N_SRC independent object-drawing FSMs (player box, enemies, eraser passes) onto the single x/y/colour/plot port of the 160x120 vga_adapter.
- Sits directly downstream of every per-object control/datapath pair; each object stalls on its own handshake instead of sharing writeEn.
- Round-robin fairness, one pixel per clock, registered output.

---
 rtl/vga_plot_arbiter.sv | 159 +++++++++++++++
 tb/tb_vga_plot_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/vga_plot_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vga_plot_arbiter
// Summary  : Round-robin merge of N_SRC pixel drawers onto one vga_adapter
//            port. It grants one pixel per clock and registers the output.
//            Define VGA_CLIP_EN to drop off-screen pixels and count them in
//            clip_count.
// Revision : 1.0
// ============================================================================
module vga_plot_arbiter #(
  parameter int N_SRC = 4,
  parameter int X_MAX = 160,
  parameter int Y_MAX = 120
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pause,
  input  logic [N_SRC-1:0]   src_req,
  input  logic [8*N_SRC-1:0] src_x,
  input  logic [7*N_SRC-1:0] src_y,
  input  logic [3*N_SRC-1:0] src_colour,
  output logic [N_SRC-1:0]   src_ack,
  output logic [7:0]         vga_x,
  output logic [6:0]         vga_y,
  output logic [2:0]         vga_colour,
  output logic               vga_plot
`ifdef VGA_CLIP_EN
  ,
  output logic [15:0]        clip_count
`endif
);

  localparam int             PTR_W = $clog2(N_SRC);
  localparam logic [PTR_W:0] N_W   = (PTR_W+1)'(N_SRC);
  localparam logic [7:0]     X_LIM = 8'(X_MAX);
  localparam logic [6:0]     Y_LIM = 7'(Y_MAX);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [7:0]       x_q, x_d;
  logic [6:0]       y_q, y_d;
  logic [2:0]       colour_q, colour_d;
  logic             plot_q, plot_d;

  logic [2*N_SRC-1:0] w_req2;
  logic [N_SRC-1:0]   w_rot;
  logic [PTR_W-1:0]   w_first;
  logic [PTR_W:0]     w_sum;
  logic [PTR_W:0]     w_inc;
  logic [PTR_W-1:0]   w_gidx;
  logic [PTR_W-1:0]   w_next;
  logic               w_grant_en;
  logic [7:0]         w_sel_x;
  logic [6:0]         w_sel_y;
  logic [2:0]         w_sel_colour;
  logic               w_on_screen;
  logic               w_plot_ok;

  // Rotate requests so bit k is the source k places after ptr.
  assign w_req2 = {src_req, src_req};
  assign w_rot  = N_SRC'(w_req2 >> ptr_q);

  always_comb begin
    w_first = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (w_rot[k]) w_first = PTR_W'(k);
    end
  end

  assign w_grant_en = reset_n & ~pause & (|src_req);
  assign w_sum      = {1'b0, ptr_q} + {1'b0, w_first};
  assign w_gidx     = (w_sum >= N_W) ? PTR_W'(w_sum - N_W) : w_sum[PTR_W-1:0];
  assign w_inc      = {1'b0, w_gidx} + (PTR_W+1)'(1);
  assign w_next     = (w_inc >= N_W) ? '0 : w_inc[PTR_W-1:0];

  always_comb begin
    src_ack = '0;
    if (w_grant_en) src_ack[w_gidx] = 1'b1;
  end

  always_comb begin
    w_sel_x      = '0;
    w_sel_y      = '0;
    w_sel_colour = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (src_ack[i]) begin
        w_sel_x      = src_x[8*i +: 8];
        w_sel_y      = src_y[7*i +: 7];
        w_sel_colour = src_colour[3*i +: 3];
      end
    end
  end

  assign w_on_screen = (w_sel_x < X_LIM) && (w_sel_y < Y_LIM);

`ifdef VGA_CLIP_EN
  logic [15:0] clip_q, clip_d;

  assign w_plot_ok = w_on_screen;

  always_comb begin
    clip_d = clip_q;
    if (w_grant_en && !w_on_screen && (clip_q != 16'hFFFF)) begin
      clip_d = clip_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) clip_q <= '0;
    else          clip_q <= clip_d;
  end

  assign clip_count = clip_q;
`else
  // Without clipping every transfer plots with its raw coordinates.
  logic w_unused_bounds;
  assign w_unused_bounds = w_on_screen;
  assign w_plot_ok       = 1'b1;
`endif

  always_comb begin
    ptr_d    = ptr_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    if (w_grant_en) begin
      ptr_d = w_next;
      if (w_plot_ok) begin
        x_d      = w_sel_x;
        y_d      = w_sel_y;
        colour_d = w_sel_colour;
        plot_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
    end
  end

  assign vga_x      = x_q;
  assign vga_y      = y_q;
  assign vga_colour = colour_q;
  assign vga_plot   = plot_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_plot_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_plot_arbiter
// Summary  : Checks directed and random traffic against a cycle-level
//            round-robin reference model.
// Revision : 1.0
// ============================================================================
module tb_vga_plot_arbiter;

  localparam int N = 4;
`ifdef VGA_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pause;
  logic [3:0]  src_req;
  logic [31:0] src_x;
  logic [27:0] src_y;
  logic [11:0] src_colour;
  logic [3:0]  src_ack;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
`ifdef VGA_CLIP_EN
  logic [15:0] clip_count;
`endif

  always #5 clk = ~clk;

  vga_plot_arbiter #(.N_SRC(N), .X_MAX(160), .Y_MAX(120)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pause      (pause),
    .src_req    (src_req),
    .src_x      (src_x),
    .src_y      (src_y),
    .src_colour (src_colour),
    .src_ack    (src_ack),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
`ifdef VGA_CLIP_EN
    ,
    .clip_count (clip_count)
`endif
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] sx [N];
  logic [6:0] sy [N];
  logic [2:0] sc [N];

  // Reference model state
  int         m_ptr;
  logic [7:0] m_x;
  logic [6:0] m_y;
  logic [2:0] m_c;
  logic       m_plot;
  int         m_clip;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_src(input int i, input int x, input int y, input int c);
    sx[i] = 8'(x);
    sy[i] = 7'(y);
    sc[i] = 3'(c);
  endtask

  // One clock: drive, check the grant, advance the model, check the outputs.
  task automatic cyc(input logic [3:0] req, input logic p, input logic rn);
    int g;
    int idx;
    logic [3:0] exp_ack;
    reset_n = rn;
    pause   = p;
    src_req = req;
    for (int i = 0; i < N; i++) begin
      src_x[8*i +: 8]      = sx[i];
      src_y[7*i +: 7]      = sy[i];
      src_colour[3*i +: 3] = sc[i];
    end
    #2;
    g = -1;
    if (rn && !p) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (g < 0 && req[idx]) g = idx;
      end
    end
    exp_ack = (g >= 0) ? 4'(1 << g) : 4'b0000;
    chk("src_ack", {28'b0, src_ack}, {28'b0, exp_ack});

    if (!rn) begin
      m_ptr = 0; m_x = '0; m_y = '0; m_c = '0; m_plot = 1'b0; m_clip = 0;
    end else if (g >= 0) begin
      m_ptr = (g + 1) % N;
      if (CLIP_EN && (int'(sx[g]) >= 160 || int'(sy[g]) >= 120)) begin
        m_plot = 1'b0;
        if (m_clip < 65535) m_clip++;
      end else begin
        m_plot = 1'b1; m_x = sx[g]; m_y = sy[g]; m_c = sc[g];
      end
    end else begin
      m_plot = 1'b0;
    end

    @(posedge clk);
    #1;
    chk("vga_plot", {31'b0, vga_plot}, {31'b0, m_plot});
    chk("vga_x", {24'b0, vga_x}, {24'b0, m_x});
    chk("vga_y", {25'b0, vga_y}, {25'b0, m_y});
    chk("vga_colour", {29'b0, vga_colour}, {29'b0, m_c});
`ifdef VGA_CLIP_EN
    chk("clip_count", {16'b0, clip_count}, 32'(m_clip));
`endif
  endtask

  initial begin
    reset_n = 1'b0; pause = 1'b0; src_req = '0;
    src_x = '0; src_y = '0; src_colour = '0;
    m_ptr = 0; m_x = '0; m_y = '0; m_c = '0; m_plot = 1'b0; m_clip = 0;
    for (int i = 0; i < N; i++) set_src(i, 20 + i, 30 + i, i + 1);
    @(posedge clk);
    #1;

    // Reset with requests pending: no grants, cleared outputs
    cyc(4'hF, 1'b0, 1'b0);
    cyc(4'hF, 1'b0, 1'b0);

    // Single pixel from source 0, then idle
    set_src(0, 10, 50, 7);
    cyc(4'b0001, 1'b0, 1'b1);
    cyc(4'b0000, 1'b0, 1'b1);

    // All sources requesting: rotating grants, one pixel per clock
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < N; i++)
        set_src(i, $urandom_range(0, 159), $urandom_range(0, 119), $urandom_range(0, 7));
      cyc(4'hF, 1'b0, 1'b1);
    end

    // Source 1 then source 2 alone, then source 3 to bring ptr back to 0
    cyc(4'b0010, 1'b0, 1'b1);
    cyc(4'b0100, 1'b0, 1'b1);
    cyc(4'b1000, 1'b0, 1'b1);

    // Pause with 0 and 3 requesting, then release
    repeat (3) cyc(4'b1001, 1'b1, 1'b1);
    cyc(4'b1001, 1'b0, 1'b1);
    cyc(4'b1000, 1'b0, 1'b1);

    // Off-screen then corner pixel from source 1
    set_src(1, 160, 5, 2);
    cyc(4'b0010, 1'b0, 1'b1);
    set_src(1, 159, 119, 5);
    cyc(4'b0010, 1'b0, 1'b1);
    set_src(1, 12, 120, 3);
    cyc(4'b0010, 1'b0, 1'b1);
    cyc(4'b0000, 1'b0, 1'b1);

    // Reset right after a transfer discards the pixel and rewinds ptr
    cyc(4'b0100, 1'b0, 1'b1);
    cyc(4'b0000, 1'b0, 1'b0);
    cyc(4'b1111, 1'b0, 1'b1);

    // Random traffic including off-screen pixels, pauses and resets
    for (int n = 0; n < 500; n++) begin
      logic [3:0] rq;
      for (int i = 0; i < N; i++)
        set_src(i, $urandom_range(0, 175), $urandom_range(0, 127), $urandom_range(0, 7));
      rq = 4'($urandom_range(0, 15));
      cyc(rq, ($urandom_range(0, 7) == 0), ($urandom_range(0, 39) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
